// File: rtl/constants_pkg.sv
// Shared constants and types for the memory-side arbitration logic.
package constants_pkg;
    localparam int ICLLEN     = 128;
    localparam int MEM_ADDR_W = 32;

    typedef enum logic [1:0] {ARB_IDLE, ARB_BUSY, ARB_RESP} arb_state_t;
    typedef enum logic {OWN_I = 1'b0, OWN_D = 1'b1} arb_owner_t;
endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin winner select; rr_last is the previous owner (1 = D).
module rr_pick2
    import constants_pkg::*;
(
    input  logic i_req,
    input  logic d_req,
    input  logic rr_last,
    output logic grant,
    output logic owner
);
    always_comb begin
        grant = i_req | d_req;
        owner = OWN_I;
        if (i_req && d_req)
            owner = (rr_last == OWN_I) ? OWN_D : OWN_I;
        else if (d_req)
            owner = OWN_D;
    end
endmodule

// File: rtl/mem_arbiter.sv
// Non-preemptive round-robin arbiter sharing the memory line port between
// the I-cache and D-cache miss paths, with a watchdog on memory completion.
module mem_arbiter
    import constants_pkg::*;
#(
    parameter int ADDR_W  = MEM_ADDR_W,
    parameter int LINE_W  = ICLLEN,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_rsp_valid,
    output logic              i_rsp_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic              d_rsp_valid,
    output logic              d_rsp_err,
    output logic [LINE_W-1:0] rsp_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_ready
);
    localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

    arb_state_t        state_q, state_d;
    arb_owner_t        owner_q, owner_d;
    arb_owner_t        rr_last_q, rr_last_d;
    logic [7:0]        wd_cnt_q, wd_cnt_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [LINE_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              i_rsp_valid_q, i_rsp_valid_d;
    logic              d_rsp_valid_q, d_rsp_valid_d;
    logic              i_rsp_err_q, i_rsp_err_d;
    logic              d_rsp_err_q, d_rsp_err_d;

    logic pick_grant;
    logic pick_owner;
    logic done;
    logic err;

    rr_pick2 u_pick (
        .i_req   (i_req),
        .d_req   (d_req),
        .rr_last (rr_last_q),
        .grant   (pick_grant),
        .owner   (pick_owner)
    );

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        rr_last_d     = rr_last_q;
        wd_cnt_d      = wd_cnt_q;
        mem_req_d     = mem_req_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        rsp_rdata_d   = rsp_rdata_q;
        i_rsp_valid_d = 1'b0;
        d_rsp_valid_d = 1'b0;
        i_rsp_err_d   = 1'b0;
        d_rsp_err_d   = 1'b0;
        done          = 1'b0;
        err           = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                if (pick_grant) begin
                    owner_d   = arb_owner_t'(pick_owner);
                    rr_last_d = arb_owner_t'(pick_owner);
                    wd_cnt_d  = 8'd0;
                    mem_req_d = 1'b1;
                    state_d   = ARB_BUSY;
                    if (pick_owner == OWN_D) begin
                        mem_we_d    = d_we;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                    end else begin
                        mem_we_d    = 1'b0;
                        mem_addr_d  = i_addr;
                        mem_wdata_d = '0;
                    end
                end
            end
            ARB_BUSY: begin
                if (mem_ready) begin
                    done = 1'b1;
                    if (!mem_we_q)
                        rsp_rdata_d = mem_rdata;
                end else if (wd_cnt_q == WD_LAST) begin
                    // Memory never answered: abandon the request and report it.
                    done        = 1'b1;
                    err         = 1'b1;
                    rsp_rdata_d = '0;
                end else begin
                    wd_cnt_d = wd_cnt_q + 8'd1;
                end
                if (done) begin
                    mem_req_d = 1'b0;
                    state_d   = ARB_RESP;
                    if (owner_q == OWN_D) begin
                        d_rsp_valid_d = 1'b1;
                        d_rsp_err_d   = err;
                    end else begin
                        i_rsp_valid_d = 1'b1;
                        i_rsp_err_d   = err;
                    end
                end
            end
            ARB_RESP: state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ARB_IDLE;
            owner_q       <= OWN_I;
            rr_last_q     <= OWN_I;
            wd_cnt_q      <= 8'd0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            rsp_rdata_q   <= '0;
            i_rsp_valid_q <= 1'b0;
            d_rsp_valid_q <= 1'b0;
            i_rsp_err_q   <= 1'b0;
            d_rsp_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            rr_last_q     <= rr_last_d;
            wd_cnt_q      <= wd_cnt_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            rsp_rdata_q   <= rsp_rdata_d;
            i_rsp_valid_q <= i_rsp_valid_d;
            d_rsp_valid_q <= d_rsp_valid_d;
            i_rsp_err_q   <= i_rsp_err_d;
            d_rsp_err_q   <= d_rsp_err_d;
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign i_rsp_valid = i_rsp_valid_q;
    assign i_rsp_err   = i_rsp_err_q;
    assign d_rsp_valid = d_rsp_valid_q;
    assign d_rsp_err   = d_rsp_err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: latency, store path, fairness, watchdog,
// mid-transaction reset and re-request behaviour.
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int LW = 128;
    localparam logic [LW-1:0] LINE1 = 128'h001080A3_003100B3_021081B3_00108093;
    localparam logic [LW-1:0] WLINE = 128'hDEAD0123_456789AB_CDEF0011_2233BEEF;
    localparam logic [LW-1:0] LINE3 = 128'h11112222_33334444_55556666_77778888;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req, d_req, d_we, mem_ready;
    logic [AW-1:0] i_addr, d_addr;
    logic [LW-1:0] d_wdata, mem_rdata;
    logic          i_rsp_valid, i_rsp_err, d_rsp_valid, d_rsp_err;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [LW-1:0] mem_wdata, rsp_rdata;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr),
        .i_rsp_valid(i_rsp_valid), .i_rsp_err(i_rsp_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rsp_valid(d_rsp_valid), .d_rsp_err(d_rsp_err),
        .rsp_rdata(rsp_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Request already driven in the current IDLE cycle (cycle 0); ends in cycle 3.
    task automatic serve(input string tag, input logic [AW-1:0] exp_addr,
                         input logic exp_we, input logic [LW-1:0] rdata);
        tick();
        chk({tag, ".req1"}, LW'(mem_req), LW'(1));
        chk({tag, ".addr"}, LW'(mem_addr), LW'(exp_addr));
        chk({tag, ".we"}, LW'(mem_we), LW'(exp_we));
        tick();
        chk({tag, ".req2"}, LW'(mem_req), LW'(1));
        mem_ready = 1'b1;
        mem_rdata = rdata;
        tick();
        mem_ready = 1'b0;
        mem_rdata = '0;
        chk({tag, ".req3"}, LW'(mem_req), LW'(0));
    endtask

    initial begin
        int first;
        int pulses;
        rst = 1'b1; i_req = 0; d_req = 0; d_we = 0; mem_ready = 0;
        i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
        tick(); tick();
        chk("rst.mem_req", LW'(mem_req), 0);
        chk("rst.addr", LW'(mem_addr), 0);
        chk("rst.rdata", rsp_rdata, 0);
        chk("rst.valid", LW'({i_rsp_valid, d_rsp_valid, i_rsp_err, d_rsp_err}), 0);
        rst = 1'b0;

        // I load with 1-cycle memory
        i_req = 1; i_addr = 32'h100;
        chk("t1.c0_req", LW'(mem_req), 0);
        serve("t1", 32'h100, 1'b0, LINE1);
        chk("t1.ivalid", LW'(i_rsp_valid), 1);
        chk("t1.dvalid", LW'(d_rsp_valid), 0);
        chk("t1.ierr", LW'(i_rsp_err), 0);
        chk("t1.rdata", rsp_rdata, LINE1);
        i_req = 0;
        tick();
        chk("t1.pulse_end", LW'(i_rsp_valid), 0);

        // D store: read data ignored, rsp_rdata keeps previous load
        d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = WLINE;
        tick();
        chk("t2.wdata", mem_wdata, WLINE);
        chk("t2.we", LW'(mem_we), 1);
        chk("t2.addr", LW'(mem_addr), 32'h40);
        mem_ready = 1; mem_rdata = LINE3;
        tick();
        mem_ready = 0; mem_rdata = '0;
        chk("t2.dvalid", LW'(d_rsp_valid), 1);
        chk("t2.ivalid", LW'(i_rsp_valid), 0);
        chk("t2.derr", LW'(d_rsp_err), 0);
        chk("t2.rdata_kept", rsp_rdata, LINE1);
        d_req = 0; d_we = 0;
        tick();
        chk("t2.pulse_end", LW'(d_rsp_valid), 0);

        // Watchdog: no mem_ready, TIMEOUT=8 -> response in cycle 9
        i_req = 1; i_addr = 32'h500;
        first = -1;
        for (int c = 1; c <= 20 && first < 0; c++) begin
            tick();
            if (i_rsp_valid) first = c;
        end
        chk("t4.resp_cycle", LW'(first), LW'(9));
        chk("t4.err", LW'(i_rsp_err), 1);
        chk("t4.rdata_zero", rsp_rdata, 0);
        chk("t4.mem_req", LW'(mem_req), 0);
        i_req = 0;
        tick();
        mem_ready = 1; mem_rdata = LINE3;
        tick();
        mem_ready = 0; mem_rdata = '0;
        chk("t4.late_valid", LW'({i_rsp_valid, d_rsp_valid}), 0);
        chk("t4.late_rdata", rsp_rdata, 0);
        chk("t4.late_req", LW'(mem_req), 0);

        // Reset during BUSY with D owning, then tie goes to D again
        d_req = 1; d_we = 0; d_addr = 32'h600;
        tick();
        chk("t5.busy", LW'(mem_req), 1);
        rst = 1; d_req = 0;
        tick();
        chk("t5.req_drop", LW'(mem_req), 0);
        chk("t5.no_rsp", LW'({i_rsp_valid, d_rsp_valid}), 0);
        rst = 0;
        i_req = 1; i_addr = 32'h610; d_req = 1; d_addr = 32'h620;
        serve("t5b", 32'h620, 1'b0, LINE3);
        chk("t5b.dvalid", LW'(d_rsp_valid), 1);
        chk("t5b.rdata", rsp_rdata, LINE3);
        i_req = 0; d_req = 0;
        tick();
        tick();

        // Fairness from reset: both held high, grants D,I,D,I
        rst = 1; tick(); rst = 0;
        i_req = 1; i_addr = 32'h200; d_req = 1; d_addr = 32'h300; d_we = 0;
        for (int k = 0; k < 4; k++) begin
            logic isd;
            isd = (k % 2 == 0);
            serve($sformatf("t3.%0d", k), isd ? 32'h300 : 32'h200, 1'b0, LINE1 ^ LW'(k));
            chk($sformatf("t3.%0d.dv", k), LW'(d_rsp_valid), LW'(isd));
            chk($sformatf("t3.%0d.iv", k), LW'(i_rsp_valid), LW'(!isd));
            tick();
        end
        i_req = 0; d_req = 0;
        tick();

        // Requester holds req one extra cycle: second transaction, single pulses
        i_req = 1; i_addr = 32'h700;
        pulses = 0;
        serve("t6a", 32'h700, 1'b0, LINE1);
        chk("t6a.ivalid", LW'(i_rsp_valid), 1);
        pulses += int'(i_rsp_valid);
        tick();
        chk("t6.gap", LW'({i_rsp_valid, mem_req}), 0);
        pulses += int'(i_rsp_valid);
        tick();
        chk("t6b.req", LW'(mem_req), 1);
        chk("t6b.addr", LW'(mem_addr), 32'h700);
        pulses += int'(i_rsp_valid);
        mem_ready = 1; mem_rdata = LINE3;
        tick();
        mem_ready = 0; mem_rdata = '0;
        chk("t6b.ivalid", LW'(i_rsp_valid), 1);
        pulses += int'(i_rsp_valid);
        i_req = 0;
        tick();
        pulses += int'(i_rsp_valid);
        chk("t6.pulses", LW'(pulses), 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single main-memory line port between the instruction-cache miss path (requester I) and the data-cache miss/writeback path (requester D).
- Non-preemptive round-robin arbitration; latches the winning request and holds it on the memory port until the memory answers.
- Returns the line and a one-cycle response pulse to the owner.
- Watchdog aborts a transaction the memory never answers and flags an error.

Parameters:
- ADDR_W, 32, byte address width of line requests.
- LINE_W, ICLLEN (128), cache line width in bits.
- TIMEOUT, 64, cycles in BUSY without mem_ready before abort; legal range 2..255.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_req  in  1  I request, level; held until i_rsp_valid
- i_addr  in  ADDR_W  I line address
- i_rsp_valid  out  1  one-cycle response pulse to I
- i_rsp_err  out  1  timeout flag, valid with i_rsp_valid
- d_req  in  1  D request, level; held until d_rsp_valid
- d_we  in  1  D store (1) or load (0)
- d_addr  in  ADDR_W  D line address
- d_wdata  in  LINE_W  D store line
- d_rsp_valid  out  1  one-cycle response pulse to D
- d_rsp_err  out  1  timeout flag, valid with d_rsp_valid
- rsp_rdata  out  LINE_W  registered load line, shared by both requesters
- mem_req  out  1  request to memory, level
- mem_we  out  1  store enable
- mem_addr  out  ADDR_W  latched address
- mem_wdata  out  LINE_W  latched store line
- mem_rdata  in  LINE_W  memory load line
- mem_ready  in  1  memory completion, one cycle

Behaviour:
- Clock is clk; reset is rst, synchronous and active-high.
- Reset:
  - state=IDLE; all outputs 0, including mem_* and rsp_rdata.
  - rr_last=I, so D wins the first tie.
  - wd_cnt=0.
  - Reset mid-transaction drops mem_req the next cycle without a response. The memory must tolerate an abandoned request.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If only one of i_req/d_req is high, grant that requester.
  - If both are high, grant the one not equal to rr_last.
  - On a grant: latch owner, mem_addr, mem_we (I always 0), and mem_wdata (I: 0); set rr_last=owner; wd_cnt=0; go to BUSY.
  - No request: stay in IDLE.
- BUSY:
  - mem_req=1; mem_* fields stay stable.
  - When mem_ready=1: register rsp_rdata=mem_rdata (load) or keep the previous value (store); err=0; go to RESP.
  - Otherwise wd_cnt++. If wd_cnt==TIMEOUT-1: err=1, rsp_rdata=0, go to RESP.
- RESP:
  - mem_req=0.
  - Owner's rsp_valid=1 for exactly one cycle; rsp_err=err. The other requester's outputs stay 0.
  - Next state IDLE.
- mem_ready is ignored outside BUSY; a late ready after a timeout is discarded.
- Requester rule: deassert req at the edge that ends the rsp_valid cycle. A req still high in the following IDLE cycle is a new transaction.
- Latency with 1-cycle memory (memory answers the cycle after mem_req rises):
  - req seen in IDLE cycle 0, mem_req cycles 1-2, mem_ready in cycle 2, rsp_valid cycle 3.
  - Back-to-back throughput is one transaction per 4 cycles.
- Fairness: with both requesting continuously, grants alternate D,I,D,I. Neither requester can be starved beyond one transaction.
- rsp_rdata holds its value until the next completion.
- Widths: wd_cnt is 8 bits and never wraps because TIMEOUT<=255.

Decomposition:
- constants_pkg: ICLLEN (existing); add MEM_ADDR_W; typedef enum {ARB_IDLE, ARB_BUSY, ARB_RESP} arb_state_t; typedef enum logic {OWN_I, OWN_D} arb_owner_t.
- Optional sub-module rr_pick2: combinational winner select from (i_req, d_req, rr_last). Everything else stays in mem_arbiter.

Test Plan:
- Reset then i_req=1, i_addr=0x100, 1-cycle memory with mem_rdata=0x001080A3_003100B3_021081B3_00108093 -> mem_req cycles 1-2, mem_addr=0x100, mem_we=0; i_rsp_valid=1 at cycle 3 only; rsp_rdata equals that line; i_rsp_err=0.
- d_req store, d_addr=0x40, d_wdata=0xDEAD...BEEF -> mem_we=1, mem_wdata matches; d_rsp_valid single pulse; i_rsp_valid stays 0.
- i_req and d_req both high for 4 transactions from reset -> grant order D,I,D,I; mem_addr sequence matches.
- mem_ready never asserted, TIMEOUT=8 -> rsp_valid with rsp_err=1 in cycle 9 after grant; rsp_rdata=0; a mem_ready pulse injected afterwards has no effect.
- rst asserted during BUSY -> next cycle mem_req=0, all rsp_valid=0; a following d_req is granted first.
- Requester holds req one extra cycle after rsp_valid -> second transaction issued to the same address; no double pulse within one transaction.
